// File: rtl/ff_seq_pkg.sv
// Shared definitions for the flip-flop test sequencer.
// FSM encoding, stimulus table and the JK reference rule.
package ff_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        PULSE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int SEQ_LEN = 8;

    // Entry i sits at STIM_TABLE[i]; each nibble is {D,J,K,T}.
    localparam logic [7:0][3:0] STIM_TABLE = {
        4'b0001, 4'b1110, 4'b0101, 4'b1011,
        4'b0000, 4'b1111, 4'b0011, 4'b1100
    };

    function automatic logic [3:0] stim_at(input logic [2:0] i);
        return STIM_TABLE[i];
    endfunction

    function automatic logic jk_next(
        input logic q,
        input logic j,
        input logic k
    );
        logic r;
        unique case ({j, k})
            2'b00:   r = q;
            2'b01:   r = 1'b0;
            2'b10:   r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ff_test_sequencer_debouncer.sv
// Button synchronizer, stability filter and press pulse.
// A held button gives a single pulse on the accepted rising level.
module step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync0;
    logic          sync1;
    logic          level;
    logic [CW-1:0] cnt;
    logic          settle;

    assign settle = (sync1 != level) && (cnt == LAST);

    // Two-stage synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn_raw;
            sync1 <= sync0;
        end
    end

    // Accept a new level only after enough identical samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level     <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            btn_pulse <= settle && sync1;
            if (sync1 == level) begin
                cnt <= '0;
            end else if (settle) begin
                level <= sync1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ff_test_sequencer.sv
// Step-by-step stimulus and checker for the D/JK/T flip-flop trio.
// One press applies one table entry, pulses ff_en and checks Q.
module ff_test_sequencer
    import ff_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_btn,
    input  logic [2:0] q,
    input  logic [2:0] qbar,
    output logic       d,
    output logic       j,
    output logic       k,
    output logic       t,
    output logic       ff_en,
    output logic [2:0] step_idx,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] err_step
);

    localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);

    state_t     state_q, state_d;
    logic [3:0] stim_q, stim_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] mq_q, mq_d;
    logic       err_q, err_d;
    logic [2:0] es_q, es_d;
    logic       step_req;
    logic       mismatch;

    step_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (step_btn),
        .btn_pulse(step_req)
    );

    // Model bits: [0]=D-FF, [1]=JK-FF, [2]=T-FF.
    assign mismatch = (q != mq_q) || (qbar != ~q);

    // Sequencer state, held stimulus, model and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stim_q  <= '0;
            idx_q   <= '0;
            mq_q    <= '0;
            err_q   <= 1'b0;
            es_q    <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            idx_q   <= idx_d;
            mq_q    <= mq_d;
            err_q   <= err_d;
            es_q    <= es_d;
        end
    end

    // Next-state: presses outside IDLE/DONE are simply dropped.
    always_comb begin
        state_d = state_q;
        stim_d  = stim_q;
        idx_d   = idx_q;
        mq_d    = mq_q;
        err_d   = err_q;
        es_d    = es_q;
        unique case (state_q)
            IDLE: begin
                if (step_req) begin
                    state_d = APPLY;
                    stim_d  = stim_at(idx_q);
                end
            end
            APPLY: begin
                state_d = PULSE;
            end
            PULSE: begin
                state_d = CHECK;
                mq_d[0] = stim_q[3];
                mq_d[1] = jk_next(mq_q[1], stim_q[2], stim_q[1]);
                mq_d[2] = mq_q[2] ^ stim_q[0];
            end
            CHECK: begin
                if (mismatch && !err_q) begin
                    err_d = 1'b1;
                    es_d  = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (step_req) begin
                    state_d = APPLY;
                    idx_d   = '0;
                    mq_d    = '0;
                    stim_d  = stim_at(3'd0);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign d        = stim_q[3];
    assign j        = stim_q[2];
    assign k        = stim_q[1];
    assign t        = stim_q[0];
    assign ff_en    = (state_q == PULSE);
    assign busy     = (state_q == APPLY) || (state_q == PULSE)
                   || (state_q == CHECK);
    assign done     = (state_q == DONE);
    assign step_idx = idx_q;
    assign error    = err_q;
    assign err_step = es_q;

endmodule

// File: doc/ff_test_sequencer.md
Name: ff_test_sequencer

Overview:
- Automatic stimulus-and-check controller for the lab's D, JK and T flip-flop trio. The flip-flops are clocked by clk and gated by this block's ff_en pulse.
- Each debounced press of the step button applies the next entry of a fixed 8-entry stimulus table to D/J/K/T.
- It then issues one ff_en pulse and compares the flip-flop Q/Qbar outputs against an internal reference model.
- Result is exposed on LEDs: step index, sticky error, failing step, done.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronized cycles required to accept a button level change (10 ms at 100 MHz).
- SEQ_LEN, 8, number of stimulus steps; fixed to the table size, legal range 1..8.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- step_btn  input  1  raw, unsynchronized push-button
- q  input  3  flip-flop Q outputs: [0]=D-FF, [1]=JK-FF, [2]=T-FF
- qbar  input  3  flip-flop Qbar outputs, same bit mapping
- d  output  1  D stimulus
- j  output  1  J stimulus
- k  output  1  K stimulus
- t  output  1  T stimulus
- ff_en  output  1  one-cycle clock-enable pulse to all three flip-flops
- step_idx  output  3  index of the next step to apply
- busy  output  1  high in APPLY, PULSE and CHECK
- done  output  1  high after the last step has been checked
- error  output  1  sticky mismatch flag
- err_step  output  3  step index of the first mismatch

Behaviour:
- Reset (async assert, sync release): state=IDLE; d=j=k=t=0; ff_en=0; step_idx=0; busy=0; done=0; error=0; err_step=0; reference model {mq_d, mq_jk, mq_t}=0; debouncer state cleared.
- Button path: 2-FF synchronizer, then the debouncer. The debounced level changes only after DEBOUNCE_CYCLES identical synchronized samples. Its rising edge produces a one-cycle step_req. A held button yields exactly one step_req.
- Stimulus table {D,J,K,T} by index 0..7: 1100, 0011, 1111, 0000, 1011, 0101, 1110, 0001.
- FSM:
  - IDLE: on step_req, go to APPLY and drive d/j/k/t from table[step_idx].
  - APPLY: 1 cycle of setup; stimulus held stable. Go to PULSE.
  - PULSE: ff_en=1 for exactly 1 cycle. Update the reference model:
    - mq_d = D
    - mq_jk per the JK truth table: 00 hold, 01 reset, 10 set, 11 toggle
    - mq_t = mq_t ^ T
  - CHECK: 1 cycle. Mismatch if q != model, or if qbar != ~q.
    - On mismatch with error=0: set error=1 and err_step=step_idx.
    - If step_idx==SEQ_LEN-1: go to DONE. Otherwise increment step_idx and go to IDLE.
  - DONE: done=1. On step_req: done=0, step_idx=0, model cleared, go to APPLY with table[0].
- Stimulus outputs hold their last value in IDLE and DONE.
- Latency: step_req to ff_en is 2 cycles; ff_en to check sample is 1 cycle.
- step_req while busy is ignored (dropped, not queued).
- error and err_step are cleared only by rst_n; a restart from DONE does not clear them.
- Reset mid-operation (including during PULSE) returns immediately to the reset values; no partial ff_en pulse.

Decomposition:
- Package ff_seq_pkg holds:
  - state encoding IDLE/APPLY/PULSE/CHECK/DONE
  - SEQ_LEN
  - the 8x4 stimulus table constant
  - JK next-state function for the reference model
- One sub-module, step_debouncer: synchronizer, stability counter, and rising-edge pulse. Parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, btn_pulse.

Test Plan:
- Correct flip-flops attached, 8 clean presses (DEBOUNCE_CYCLES=4 in sim):
  - ff_en pulses exactly 8 times.
  - Final q=3'b100 (qd=0, qjk=0, qt=1).
  - done=1, error=0, step_idx=7.
- T-FF model forced so q[2] is stuck at 0: error rises in CHECK of step 1, err_step=1. error stays 1 through the remaining steps and through a restart from DONE.
- Button glitch of 3 cycles, then a 1000-cycle hold: the glitch produces no step_req; the hold produces exactly one ff_en, and step_idx goes 0→1.
- Second press arriving during APPLY/PULSE/CHECK: dropped; only one ff_en pulse for that step.
- rst_n asserted in the PULSE cycle of step 3: ff_en drops the same cycle; all outputs return to 0; the next press applies table[0]=1100.
- Force qbar[1]=q[1] at step 5: error=1, err_step=5, while q itself matches the model.
